// File: rtl/jedro_1_mem_arbiter.sv
// Two-master arbiter (instruction fetch + load/store) for one single-port synchronous RAM.
// Define JEDRO_1_MEM_ARB_ROUND_ROBIN_EN for round-robin contention instead of data priority with a starvation guard.
module jedro_1_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_gnt_o,
   output logic                    if_rvalid_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   input  logic                    lsu_req_i,
   input  logic                    lsu_we_i,
   input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
   output logic                    lsu_gnt_o,
   output logic                    lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
   output logic                    mem_en_o,
   output logic [DATA_WIDTH/8-1:0] mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = 4;

   logic rst_q;
   logic block;
   logic if_win;
   logic lsu_win;
   logic tag_valid;
   logic tag_lsu;
   logic rsp_ok;

   // Grants are suppressed in the reset cycle and the cycle right after it.
   assign block = rst_i | rst_q;

`ifdef JEDRO_1_MEM_ARB_ROUND_ROBIN_EN
   logic rr_last;

   always_comb begin
      if_win  = 1'b0;
      lsu_win = 1'b0;
      if (!block) begin
         if (if_req_i && lsu_req_i) begin
            if (rr_last) if_win  = 1'b1;
            else         lsu_win = 1'b1;
         end else begin
            if_win  = if_req_i;
            lsu_win = lsu_req_i;
         end
      end
   end

   // rr_last: 0 = fetch won last, 1 = load/store won last
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_last <= 1'b0;
      end else if (lsu_win) begin
         rr_last <= 1'b1;
      end else if (if_win) begin
         rr_last <= 1'b0;
      end
   end
`else
   logic [CNT_WIDTH-1:0] starve_cnt;
   logic                 starved;

   assign starved = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));

   always_comb begin
      if_win  = 1'b0;
      lsu_win = 1'b0;
      if (!block) begin
         if (if_req_i && lsu_req_i) begin
            if (starved) if_win  = 1'b1;
            else         lsu_win = 1'b1;
         end else begin
            if_win  = if_req_i;
            lsu_win = lsu_req_i;
         end
      end
   end

   // Counts consecutive lost fetch cycles; held at zero through the post-reset blackout.
   always_ff @(posedge clk_i) begin
      if (rst_i || rst_q) begin
         starve_cnt <= '0;
      end else if (!if_req_i || if_win) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + CNT_WIDTH'(1);
      end
   end
`endif

   assign if_gnt_o  = if_win;
   assign lsu_gnt_o = lsu_win;

   // RAM request muxed from the winner; idle drives zeros.
   always_comb begin
      mem_en_o    = if_win | lsu_win;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (lsu_win) begin
         mem_addr_o  = lsu_addr_i;
         mem_wdata_o = lsu_wdata_i;
         if (lsu_we_i) mem_we_o = BE_WIDTH'(lsu_be_i);
      end else if (if_win) begin
         mem_addr_o = if_addr_i;
      end
   end

   // One-deep owner tag for the read issued this cycle.
   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (rst_i) begin
         tag_valid <= 1'b0;
         tag_lsu   <= 1'b0;
      end else begin
         tag_valid <= if_win | (lsu_win & ~lsu_we_i);
         tag_lsu   <= lsu_win;
      end
   end

   // A read in flight when reset arrives is dropped.
   assign rsp_ok       = tag_valid & ~rst_i;
   assign if_rvalid_o  = rsp_ok & ~tag_lsu;
   assign lsu_rvalid_o = rsp_ok & tag_lsu;
   assign if_rdata_o   = if_rvalid_o  ? mem_rdata_i : '0;
   assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter with a behavioural 1-cycle-latency RAM and a response scoreboard.
module tb_jedro_1_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        lsu_req;
   logic        lsu_we;
   logic [3:0]  lsu_be;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   typedef struct {
      bit          is_lsu;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [31:0] ram     [256];
   logic [31:0] ref_mem [256];
   int          cyc_n = 0;
   int          n_vec = 0;
   int          n_err = 0;

   jedro_1_mem_arbiter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_gnt_o     (if_gnt),
      .if_rvalid_o  (if_rvalid),
      .if_rdata_o   (if_rdata),
      .lsu_req_i    (lsu_req),
      .lsu_we_i     (lsu_we),
      .lsu_be_i     (lsu_be),
      .lsu_addr_i   (lsu_addr),
      .lsu_wdata_i  (lsu_wdata),
      .lsu_gnt_o    (lsu_gnt),
      .lsu_rvalid_o (lsu_rvalid),
      .lsu_rdata_o  (lsu_rdata),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Behavioural RAM: byte-enabled writes, registered read data.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr[9:2]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard when a response is due, otherwise requires silence.
   always @(negedge clk) begin
      if (q.size() != 0 && q[0].due == cyc_n) begin
         mon_e = q.pop_front();
         check("lsu_rvalid", 32'(lsu_rvalid), 32'(mon_e.is_lsu));
         check("if_rvalid",  32'(if_rvalid),  32'(!mon_e.is_lsu));
         check(mon_e.is_lsu ? "lsu_rdata" : "if_rdata",
               mon_e.is_lsu ? lsu_rdata : if_rdata, mon_e.data);
         check(mon_e.is_lsu ? "if_rdata_idle" : "lsu_rdata_idle",
               mon_e.is_lsu ? if_rdata : lsu_rdata, 32'h0);
      end else begin
         check("rvalid_idle", 32'({if_rvalid, lsu_rvalid}), 32'h0);
         check("rdata_idle",  if_rdata | lsu_rdata, 32'h0);
      end
   end

   // One cycle: drive requests, check arbitration/RAM muxing mid-cycle, record expected responses.
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [3:0] lbe,
                       input logic [31:0] la, input logic [31:0] lwd,
                       input logic exp_if, input logic exp_lsu);
      exp_t e;
      if_req    = ir;
      if_addr   = ia;
      lsu_req   = lr;
      lsu_we    = lw;
      lsu_be    = lbe;
      lsu_addr  = la;
      lsu_wdata = lwd;
      @(negedge clk);
      check("if_gnt",  32'(if_gnt),  32'(exp_if));
      check("lsu_gnt", 32'(lsu_gnt), 32'(exp_lsu));
      check("mem_en",  32'(mem_en),  32'(exp_if | exp_lsu));
      check("mem_we",  32'(mem_we),  (exp_lsu && lw) ? 32'(lbe) : 32'h0);
      check("mem_addr", mem_addr, exp_lsu ? la : (exp_if ? ia : 32'h0));
      check("mem_wdata", mem_wdata, exp_lsu ? lwd : 32'h0);
      if (exp_lsu && lw) begin
         for (int b = 0; b < 4; b++)
            if (lbe[b]) ref_mem[la[9:2]][8*b +: 8] = lwd[8*b +: 8];
      end else if (exp_lsu) begin
         e.is_lsu = 1'b1; e.data = ref_mem[la[9:2]]; e.due = cyc_n + 1;
         q.push_back(e);
      end else if (exp_if) begin
         e.is_lsu = 1'b0; e.data = ref_mem[ia[9:2]]; e.due = cyc_n + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
      ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;

      // Reset held 3 cycles with both masters requesting, then one blackout cycle.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 0, 0);
      rst = 1'b0;
      step(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 0, 0);
      step(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 0, 1);
      step(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);

      // Fetch-only back-to-back reads.
      step(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
      step(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
      step(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);

      // Partial store then load of the same word.
      step(0, 32'h0, 1, 1, 4'b0011, 32'h40, 32'hDEADBEEF, 0, 1);
      step(0, 32'h0, 1, 0, 4'b0000, 32'h40, 32'h0,       0, 1);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      check("write_merge_model", ref_mem[8'h10], 32'h0000BEEF);

      // Reset arrives the cycle after a load grant: response must be dropped.
      step(0, 32'h0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 1);
      void'(q.pop_back());
      rst = 1'b1;
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      step(1, 32'h8, 1, 0, 4'h0, 32'h4, 32'h0, 0, 0);
      rst = 1'b0;
      step(1, 32'h8, 1, 0, 4'h0, 32'h4, 32'h0, 0, 0);

      // Continuous contention straight out of reset.
      for (int k = 0; k < 10; k++) begin
`ifdef JEDRO_1_MEM_ARB_ROUND_ROBIN_EN
         step(1, 32'h8, 1, 0, 4'h0, 32'h4, 32'h0, (k % 2) == 1, (k % 2) == 0);
`else
         step(1, 32'h8, 1, 0, 4'h0, 32'h4, 32'h0, (k % 5) == 4, (k % 5) != 4);
`endif
      end
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);

      check("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
